// File: rtl/cdma_dma_pkg.sv
// Shared CDMA<->MCIF read-path payload layouts and field positions.
// Imported by the read-latency buffer and its storage sub-module.
package cdma_dma_pkg;

    localparam int unsigned REQ_PD_W = 79;
    localparam int unsigned RSP_PD_W = 257;
    localparam int unsigned ADDR_MSB = 63;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned SIZE_MSB = 78;
    localparam int unsigned SIZE_LSB = 64;
    localparam int unsigned MASK_BIT = 256;

    typedef struct packed {
        logic [SIZE_MSB-SIZE_LSB:0] size;
        logic [ADDR_MSB:ADDR_LSB]   addr;
    } req_pd_t;

    typedef struct packed {
        logic                mask;
        logic [MASK_BIT-1:0] data;
    } rsp_pd_t;

    // Beats a request will return; 16 bits so size = 0x7fff cannot wrap.
    function automatic logic [15:0] req_need(input req_pd_t pd);
        return {1'b0, pd.size} + 16'd1;
    endfunction

endpackage

// File: rtl/cdma_lat_fifo_ram.sv
// Response beat storage: one synchronous write port, asynchronous head read.
// Pointer and flag management lives in the parent.
module cdma_lat_fifo_ram
    import cdma_dma_pkg::*;
#(
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  rsp_pd_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output rsp_pd_t       rd_data
);

    rsp_pd_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cdma_rd_lat_fifo.sv
// Credit-managed read-latency buffer: a request reaches MCIF only after its
// returning beats have reserved space, so responses never back-pressure MCIF.
module cdma_rd_lat_fifo
    import cdma_dma_pkg::*;
#(
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dma_rd_req_valid,
    output logic                dma_rd_req_ready,
    input  logic [REQ_PD_W-1:0] dma_rd_req_pd,
    output logic                mcif_rd_req_valid,
    input  logic                mcif_rd_req_ready,
    output logic [REQ_PD_W-1:0] mcif_rd_req_pd,
    input  logic                mcif_rd_rsp_valid,
    output logic                mcif_rd_rsp_ready,
    input  logic [RSP_PD_W-1:0] mcif_rd_rsp_pd,
    output logic                dma_rd_rsp_valid,
    input  logic                dma_rd_rsp_ready,
    output logic [RSP_PD_W-1:0] dma_rd_rsp_pd,
    output logic [CNT_W-1:0]    outstanding,
    output logic                idle,
    output logic                err_oversize,
    output logic                err_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CNT_W-1:0] free;
    logic             req_vld;
    req_pd_t          req_pd;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    req_pd_t          req_in;
    logic [15:0]      need;
    logic [CNT_W-1:0] need_c;
    logic             credit_ok;
    logic             oversize;
    logic             take_ok;
    logic             load;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    rsp_pd_t          head;

    assign req_in    = req_pd_t'(dma_rd_req_pd);
    assign need      = req_need(req_in);
    assign need_c    = need[CNT_W-1:0];
    assign credit_ok = 32'(free) >= 32'(need);
    assign oversize  = 32'(need) > DEPTH;

    // Pop credits of the current cycle are deliberately not counted here.
    assign take_ok = !reset && credit_ok && (!req_vld || mcif_rd_req_ready);
    assign load    = dma_rd_req_valid && take_ok;

    assign full  = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty = wptr == rptr;
    assign push  = mcif_rd_rsp_valid && !full;
    assign pop   = !empty && dma_rd_rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            free    <= CNT_W'(DEPTH);
            req_vld <= 1'b0;
            req_pd  <= '0;
        end else begin
            free <= free - (load ? need_c : '0) + CNT_W'(pop);
            if (load) begin
                req_vld <= 1'b1;
                req_pd  <= req_in;
            end else if (mcif_rd_req_ready) begin
                req_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_oversize <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (dma_rd_req_valid && oversize) begin
                err_oversize <= 1'b1;
            end
            if (mcif_rd_rsp_valid && full) begin
                err_overflow <= 1'b1;
            end
        end
    end

    cdma_lat_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (rsp_pd_t'(mcif_rd_rsp_pd)),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (head)
    );

    assign dma_rd_req_ready  = take_ok;
    assign mcif_rd_req_valid = req_vld;
    assign mcif_rd_req_pd    = req_pd;
    assign mcif_rd_rsp_ready = !full;
    assign dma_rd_rsp_valid  = !empty;
    // Unwritten storage is never exposed: the head reads as zero when empty.
    assign dma_rd_rsp_pd     = empty ? '0 : head;
    assign outstanding       = CNT_W'(DEPTH) - free;
    assign idle              = (free == CNT_W'(DEPTH)) && !req_vld;

endmodule

// File: tb/tb_cdma_rd_lat_fifo.sv
// Self-checking bench for cdma_rd_lat_fifo: directed scenarios plus random
// traffic, all compared against a queue-based credit/FIFO reference model.
module tb_cdma_rd_lat_fifo;

    localparam int DEPTH = 128;

    logic         clock = 1'b0;
    logic         reset;
    logic         dma_rd_req_valid;
    logic         dma_rd_req_ready;
    logic [78:0]  dma_rd_req_pd;
    logic         mcif_rd_req_valid;
    logic         mcif_rd_req_ready;
    logic [78:0]  mcif_rd_req_pd;
    logic         mcif_rd_rsp_valid;
    logic         mcif_rd_rsp_ready;
    logic [256:0] mcif_rd_rsp_pd;
    logic         dma_rd_rsp_valid;
    logic         dma_rd_rsp_ready;
    logic [256:0] dma_rd_rsp_pd;
    logic [7:0]   outstanding;
    logic         idle;
    logic         err_oversize;
    logic         err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int           m_free;
    bit           m_reqv;
    logic [78:0]  m_reqpd;
    logic [256:0] m_q[$];
    bit           m_ovs;
    bit           m_ovf;

    cdma_rd_lat_fifo #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .dma_rd_req_valid  (dma_rd_req_valid),
        .dma_rd_req_ready  (dma_rd_req_ready),
        .dma_rd_req_pd     (dma_rd_req_pd),
        .mcif_rd_req_valid (mcif_rd_req_valid),
        .mcif_rd_req_ready (mcif_rd_req_ready),
        .mcif_rd_req_pd    (mcif_rd_req_pd),
        .mcif_rd_rsp_valid (mcif_rd_rsp_valid),
        .mcif_rd_rsp_ready (mcif_rd_rsp_ready),
        .mcif_rd_rsp_pd    (mcif_rd_rsp_pd),
        .dma_rd_rsp_valid  (dma_rd_rsp_valid),
        .dma_rd_rsp_ready  (dma_rd_rsp_ready),
        .dma_rd_rsp_pd     (dma_rd_rsp_pd),
        .outstanding       (outstanding),
        .idle              (idle),
        .err_oversize      (err_oversize),
        .err_overflow      (err_overflow)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [256:0] rand_beat();
        logic [256:0] b = '0;
        for (int k = 0; k < 9; k++) b = (b << 32) | 257'($urandom);
        return b;
    endfunction

    function automatic logic [78:0] mk_req(input int size);
        return {15'(size), $urandom, $urandom};
    endfunction

    function automatic bit exp_req_ready();
        int need = int'(dma_rd_req_pd[78:64]) + 1;
        return !reset && (m_free >= need) && (!m_reqv || mcif_rd_req_ready);
    endfunction

    // Clock edge plus reference-model update from the inputs seen at the edge.
    task automatic advance();
        int          need;
        bit          load, push, pop;
        logic [256:0] beat;
        need = int'(dma_rd_req_pd[78:64]) + 1;
        load = dma_rd_req_valid && exp_req_ready();
        push = mcif_rd_rsp_valid && (m_q.size() < DEPTH);
        pop  = (m_q.size() > 0) && dma_rd_rsp_ready;
        beat = mcif_rd_rsp_pd;
        if (reset) begin
            m_free = DEPTH; m_reqv = 0; m_reqpd = '0; m_q.delete(); m_ovs = 0; m_ovf = 0;
        end else begin
            if (dma_rd_req_valid && need > DEPTH) m_ovs = 1;
            if (mcif_rd_rsp_valid && m_q.size() == DEPTH) m_ovf = 1;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(beat);
            m_free = m_free - (load ? need : 0) + (pop ? 1 : 0);
            if (load) begin
                m_reqv = 1; m_reqpd = dma_rd_req_pd;
            end else if (mcif_rd_req_ready) begin
                m_reqv = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_quiet();
        dma_rd_req_valid  = 0;
        dma_rd_req_pd     = '0;
        mcif_rd_req_ready = 1;
        mcif_rd_rsp_valid = 0;
        mcif_rd_rsp_pd    = '0;
        dma_rd_rsp_ready  = 0;
    endtask

    // Return `beats` owed responses and pop everything buffered.
    task automatic drain(input int beats);
        int left   = beats;
        int budget = 4 * beats + 50;
        dma_rd_rsp_ready = 1;
        while ((left > 0 || m_q.size() > 0) && budget > 0) begin
            mcif_rd_rsp_valid = (left > 0);
            mcif_rd_rsp_pd    = rand_beat();
            advance();
            if (left > 0) left--;
            budget--;
        end
        mcif_rd_rsp_valid = 0;
        dma_rd_rsp_ready  = 0;
    endtask

    task automatic test_reset();
        set_quiet();
        reset = 1;
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(3);
        advance();
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_ready got %b exp 0", dma_rd_req_ready);
        end
        advance();
        reset = 0;
        set_quiet();
        #1;
        n_tests++;
        if (outstanding !== 8'd0 || idle !== 1'b1 || mcif_rd_rsp_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_counters got out=%0d idle=%b rsp_rdy=%b exp 0 1 1",
                               outstanding, idle, mcif_rd_rsp_ready);
        end
        n_tests++;
        if ({mcif_rd_req_valid, dma_rd_rsp_valid, err_oversize, err_overflow} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0000",
                               {mcif_rd_req_valid, dma_rd_rsp_valid, err_oversize, err_overflow});
        end
        n_tests++;
        if (mcif_rd_req_pd !== '0 || dma_rd_rsp_pd !== '0) begin
            n_fail++; $display("FAIL reset_pd got %h / %h exp 0", mcif_rd_req_pd, dma_rd_rsp_pd);
        end
    endtask

    task automatic test_single_request();
        logic [78:0] pd = mk_req(3);
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = pd;
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready got %b exp 1", dma_rd_req_ready);
        end
        advance();
        dma_rd_req_valid = 0;
        #1;
        n_tests++;
        if (mcif_rd_req_valid !== 1'b1 || mcif_rd_req_pd !== pd || outstanding !== 8'd4) begin
            n_fail++; $display("FAIL single_fwd got v=%b pd=%h out=%0d exp 1 %h 4",
                               mcif_rd_req_valid, mcif_rd_req_pd, outstanding, pd);
        end
        advance();
        n_tests++;
        if (mcif_rd_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_clear got %b exp 0", mcif_rd_req_valid);
        end
        for (int i = 0; i < 4; i++) begin
            mcif_rd_rsp_valid = 1;
            mcif_rd_rsp_pd    = rand_beat();
            #1;
            n_tests++;
            if (dma_rd_rsp_valid !== (i > 0)) begin
                n_fail++; $display("FAIL rsp_latency got %b exp %b", dma_rd_rsp_valid, i > 0);
            end
            advance();
        end
        mcif_rd_rsp_valid = 0;
        dma_rd_rsp_ready  = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (dma_rd_rsp_valid !== 1'b1 || dma_rd_rsp_pd !== m_q[0]) begin
                n_fail++; $display("FAIL single_pop got v=%b pd=%h exp 1 %h",
                                   dma_rd_rsp_valid, dma_rd_rsp_pd, m_q[0]);
            end
            advance();
        end
        dma_rd_rsp_ready = 0;
        #1;
        n_tests++;
        if (outstanding !== 8'd0 || idle !== 1'b1 || dma_rd_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_done got out=%0d idle=%b v=%b exp 0 1 0",
                               outstanding, idle, dma_rd_rsp_valid);
        end
    endtask

    task automatic test_credit_stall();
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(99);
        advance();
        dma_rd_req_pd = mk_req(31);
        #1;
        n_tests++;
        if (outstanding !== 8'd100 || dma_rd_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_start got out=%0d rdy=%b exp 100 0",
                               outstanding, dma_rd_req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            mcif_rd_rsp_valid = 1;
            mcif_rd_rsp_pd    = rand_beat();
            advance();
        end
        mcif_rd_rsp_valid = 0;
        dma_rd_rsp_ready  = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (dma_rd_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold pop%0d got %b exp 0", i, dma_rd_req_ready);
            end
            advance();
        end
        dma_rd_rsp_ready = 0;
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got %b exp 1", dma_rd_req_ready);
        end
        advance();
        dma_rd_req_valid = 0;
        #1;
        n_tests++;
        if (outstanding !== 8'd128) begin
            n_fail++; $display("FAIL stall_after got out=%0d exp 128", outstanding);
        end
        drain(128);
        #1;
        n_tests++;
        if (outstanding !== 8'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL stall_drain got out=%0d idle=%b exp 0 1", outstanding, idle);
        end
    endtask

    task automatic test_simultaneous();
        logic [78:0] pd_a = mk_req(0);
        logic [78:0] pd_b = mk_req(0);
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(0);
        advance();
        dma_rd_req_valid  = 0;
        mcif_rd_rsp_valid = 1;
        mcif_rd_rsp_pd    = rand_beat();
        advance();
        mcif_rd_rsp_valid = 0;
        dma_rd_req_valid  = 1;
        dma_rd_req_pd     = pd_a;
        dma_rd_rsp_ready  = 1;
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b1 || outstanding !== 8'd1) begin
            n_fail++; $display("FAIL simul_pre got rdy=%b out=%0d exp 1 1", dma_rd_req_ready, outstanding);
        end
        advance();
        dma_rd_rsp_ready  = 0;
        mcif_rd_req_ready = 0;
        dma_rd_req_pd     = pd_b;
        #1;
        n_tests++;
        if (outstanding !== 8'd1) begin
            n_fail++; $display("FAIL simul_free got out=%0d exp 1", outstanding);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (mcif_rd_req_valid !== 1'b1 || mcif_rd_req_pd !== pd_a || dma_rd_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_stable got v=%b pd=%h rdy=%b exp 1 %h 0",
                                   mcif_rd_req_valid, mcif_rd_req_pd, dma_rd_req_ready, pd_a);
            end
            advance();
        end
        mcif_rd_req_ready = 1;
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reload_ready got %b exp 1", dma_rd_req_ready);
        end
        advance();
        dma_rd_req_valid = 0;
        #1;
        n_tests++;
        if (mcif_rd_req_pd !== pd_b || outstanding !== 8'd2) begin
            n_fail++; $display("FAIL reload got pd=%h out=%0d exp %h 2", mcif_rd_req_pd, outstanding, pd_b);
        end
        drain(2);
        #1;
        n_tests++;
        if (outstanding !== 8'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL simul_drain got out=%0d idle=%b exp 0 1", outstanding, idle);
        end
    endtask

    task automatic test_fifo_full_wrap();
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(127);
        advance();
        dma_rd_req_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mcif_rd_rsp_valid = 1;
            mcif_rd_rsp_pd    = rand_beat();
            #1;
            n_tests++;
            if (mcif_rd_rsp_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_ready beat%0d got 0 exp 1", i);
            end
            advance();
        end
        mcif_rd_rsp_valid = 0;
        #1;
        n_tests++;
        if (mcif_rd_rsp_ready !== 1'b0 || err_overflow !== 1'b0 || outstanding !== 8'd128) begin
            n_fail++; $display("FAIL full_flags got rdy=%b ovf=%b out=%0d exp 0 0 128",
                               mcif_rd_rsp_ready, err_overflow, outstanding);
        end
        mcif_rd_rsp_valid = 1;
        mcif_rd_rsp_pd    = rand_beat();
        advance();
        mcif_rd_rsp_valid = 0;
        #1;
        n_tests++;
        if (err_overflow !== 1'b1 || dma_rd_rsp_pd !== m_q[0]) begin
            n_fail++; $display("FAIL overflow got ovf=%b pd=%h exp 1 %h", err_overflow, dma_rd_rsp_pd, m_q[0]);
        end
        dma_rd_rsp_ready = 1;
        advance();
        dma_rd_rsp_ready = 0;
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(0);
        #1;
        n_tests++;
        if (mcif_rd_rsp_ready !== 1'b1 || dma_rd_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_pop got rsp_rdy=%b req_rdy=%b exp 1 1",
                               mcif_rd_rsp_ready, dma_rd_req_ready);
        end
        advance();
        dma_rd_req_valid  = 0;
        mcif_rd_rsp_valid = 1;
        mcif_rd_rsp_pd    = rand_beat();
        advance();
        mcif_rd_rsp_valid = 0;
        dma_rd_rsp_ready  = 1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_tests++;
            if (dma_rd_rsp_valid !== 1'b1 || dma_rd_rsp_pd !== m_q[0]) begin
                n_fail++; $display("FAIL wrap_order beat%0d got %h exp %h", i, dma_rd_rsp_pd, m_q[0]);
            end
            advance();
        end
        dma_rd_rsp_ready = 0;
        #1;
        n_tests++;
        if (dma_rd_rsp_valid !== 1'b0 || outstanding !== 8'd0 || err_overflow !== 1'b1) begin
            n_fail++; $display("FAIL wrap_done got v=%b out=%0d ovf=%b exp 0 0 1",
                               dma_rd_rsp_valid, outstanding, err_overflow);
        end
    endtask

    task automatic test_oversize_reset();
        dma_rd_req_valid = 1;
        dma_rd_req_pd    = mk_req(128);
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b0 || err_oversize !== 1'b0) begin
            n_fail++; $display("FAIL oversize_pre got rdy=%b ovs=%b exp 0 0", dma_rd_req_ready, err_oversize);
        end
        advance();
        n_tests++;
        if (err_oversize !== 1'b1) begin
            n_fail++; $display("FAIL oversize_set got %b exp 1", err_oversize);
        end
        for (int i = 0; i < 5; i++) advance();
        dma_rd_req_valid = 0;
        advance();
        n_tests++;
        if (err_oversize !== 1'b1 || mcif_rd_req_valid !== 1'b0 || outstanding !== 8'd0) begin
            n_fail++; $display("FAIL oversize_sticky got ovs=%b v=%b out=%0d exp 1 0 0",
                               err_oversize, mcif_rd_req_valid, outstanding);
        end
        mcif_rd_req_ready = 0;
        dma_rd_req_valid  = 1;
        dma_rd_req_pd     = mk_req(7);
        advance();
        dma_rd_req_pd = mk_req(2);
        for (int i = 0; i < 3; i++) begin
            mcif_rd_rsp_valid = 1;
            mcif_rd_rsp_pd    = rand_beat();
            advance();
        end
        #1;
        n_tests++;
        if (outstanding !== 8'd8 || mcif_rd_req_valid !== 1'b1 || dma_rd_rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL midburst got out=%0d v=%b rv=%b exp 8 1 1",
                               outstanding, mcif_rd_req_valid, dma_rd_rsp_valid);
        end
        reset = 1;
        #1;
        n_tests++;
        if (dma_rd_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_ready got %b exp 0", dma_rd_req_ready);
        end
        advance();
        reset = 0;
        set_quiet();
        #1;
        n_tests++;
        if ({mcif_rd_req_valid, dma_rd_rsp_valid, err_oversize, err_overflow, idle, mcif_rd_rsp_ready} !== 6'b000011
            || outstanding !== 8'd0 || mcif_rd_req_pd !== '0 || dma_rd_rsp_pd !== '0) begin
            n_fail++; $display("FAIL reset_mid got flags=%b out=%0d exp 000011 0",
                               {mcif_rd_req_valid, dma_rd_rsp_valid, err_oversize, err_overflow, idle,
                                mcif_rd_rsp_ready}, outstanding);
        end
    endtask

    task automatic test_back_to_back();
        int owed = 0;
        int budget;
        bit handoff, push;
        int hs_beats;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dma_rd_req_valid  = ($urandom % 3) != 0;
            dma_rd_req_pd     = mk_req(($urandom % 8 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3)));
            mcif_rd_req_ready = ($urandom % 4) != 0;
            mcif_rd_rsp_valid = (owed > 0) && (($urandom % 4) != 0);
            mcif_rd_rsp_pd    = rand_beat();
            dma_rd_rsp_ready  = ($urandom % 3) != 0;
            #1;
            n_tests++;
            if (dma_rd_req_ready !== exp_req_ready()) begin
                n_fail++; $display("FAIL rnd_req_ready cyc%0d got %b exp %b", cyc, dma_rd_req_ready, exp_req_ready());
            end
            n_tests++;
            if (mcif_rd_req_valid !== m_reqv || (m_reqv && mcif_rd_req_pd !== m_reqpd)) begin
                n_fail++; $display("FAIL rnd_mcif_req cyc%0d got %b %h exp %b %h",
                                   cyc, mcif_rd_req_valid, mcif_rd_req_pd, m_reqv, m_reqpd);
            end
            n_tests++;
            if (dma_rd_rsp_valid !== (m_q.size() > 0) || (m_q.size() > 0 && dma_rd_rsp_pd !== m_q[0])) begin
                n_fail++; $display("FAIL rnd_rsp cyc%0d got v=%b pd=%h exp v=%b",
                                   cyc, dma_rd_rsp_valid, dma_rd_rsp_pd, m_q.size() > 0);
            end
            n_tests++;
            if (outstanding !== 8'(DEPTH - m_free) || idle !== (m_free == DEPTH && !m_reqv)
                || mcif_rd_rsp_ready !== (m_q.size() < DEPTH)) begin
                n_fail++; $display("FAIL rnd_status cyc%0d got out=%0d idle=%b rdy=%b exp out=%0d",
                                   cyc, outstanding, idle, mcif_rd_rsp_ready, DEPTH - m_free);
            end
            handoff  = m_reqv && mcif_rd_req_ready;
            hs_beats = int'(m_reqpd[78:64]) + 1;
            push     = mcif_rd_rsp_valid;
            advance();
            if (handoff) owed += hs_beats;
            if (push) owed--;
        end
        set_quiet();
        dma_rd_rsp_ready = 1;
        budget = 2000;
        while ((m_reqv || owed > 0 || m_q.size() > 0) && budget > 0) begin
            handoff  = m_reqv && mcif_rd_req_ready;
            hs_beats = int'(m_reqpd[78:64]) + 1;
            mcif_rd_rsp_valid = owed > 0;
            mcif_rd_rsp_pd    = rand_beat();
            push = mcif_rd_rsp_valid;
            advance();
            if (handoff) owed += hs_beats;
            if (push) owed--;
            budget--;
        end
        set_quiet();
        #1;
        n_tests++;
        if (budget == 0 || outstanding !== 8'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL rnd_drain got out=%0d idle=%b budget=%0d exp 0 1 >0",
                               outstanding, idle, budget);
        end
    endtask

    initial begin
        m_free = DEPTH; m_reqv = 0; m_reqpd = '0; m_ovs = 0; m_ovf = 0;
        reset = 1;
        set_quiet();
        test_reset();
        test_single_request();
        test_credit_stall();
        test_simultaneous();
        test_fifo_full_wrap();
        test_oversize_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
